// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor.
// Control-flow instruction kinds, 2-bit direction counter states, default table size.
package branch_predictor_pkg;

  typedef enum logic [2:0] {
    ITYPE_ALU    = 3'd0,
    ITYPE_LOAD   = 3'd1,
    ITYPE_STORE  = 3'd2,
    ITYPE_BRANCH = 3'd3,
    ITYPE_JAL    = 3'd4,
    ITYPE_JALR   = 3'd5
  } inst_type_t;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_ctr_t;

  localparam int BP_ENTRIES_DEFAULT = 16;

endpackage

// File: rtl/branch_predictor_sat.sv
// Two-bit saturating direction counter, next-state only.
// Moves one step toward ST when inc is set, otherwise one step toward SNT.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t cur,
  input  logic    inc,
  output bp_ctr_t next
);

  always_comb begin
    next = cur;
    unique case (cur)
      SNT: next = inc ? WNT : SNT;
      WNT: next = inc ? WT  : SNT;
      WT:  next = inc ? ST  : WNT;
      ST:  next = inc ? ST  : WT;
      default: next = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit BHT counter.
// Lookup is combinational from registered state; updates land at the clock edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BP_ENTRIES = BP_ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  inst_type_t  upd_inst_type,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        flush_all,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(BP_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [BP_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BP_ENTRIES];
  logic [31:0]      tgt_q   [BP_ENTRIES];
  bp_ctr_t          ctr_q   [BP_ENTRIES];
  logic [31:0]      cnt_q;

  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  logic             fhit;
  logic [1:0]       fctr;

  assign fidx = fetch_pc[IDX_W+1:2];
  assign ftag = fetch_pc[31:IDX_W+2];
  assign fhit = valid_q[fidx] && (tag_q[fidx] == ftag);
  assign fctr = ctr_q[fidx];

  assign pred_taken  = fhit && fctr[1];
  assign pred_target = pred_taken ? tgt_q[fidx] : fetch_pc + 32'd4;

  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic             is_br;
  logic             is_j;
  logic             wr_en;
  logic             cnt_en;
  bp_ctr_t          sat_next;
  bp_ctr_t          wr_ctr;
  logic [31:0]      wr_tgt;

  assign uidx  = upd_pc[IDX_W+1:2];
  assign utag  = upd_pc[31:IDX_W+2];
  assign uhit  = valid_q[uidx] && (tag_q[uidx] == utag);
  assign is_br = (upd_inst_type == ITYPE_BRANCH);
  assign is_j  = (upd_inst_type == ITYPE_JAL) ||
                 (upd_inst_type == ITYPE_JALR);

  sat_counter2 u_sat (
    .cur  (ctr_q[uidx]),
    .inc  (upd_taken),
    .next (sat_next)
  );

  // A not-taken branch that misses never allocates.
  assign wr_en = upd_valid && !flush_all &&
                 (is_j || (is_br && (uhit || upd_taken)));

  assign cnt_en = upd_valid && upd_mispredict && (is_br || is_j);

  assign wr_ctr = is_j ? ST : (uhit ? sat_next : WT);
  assign wr_tgt = (is_j || upd_taken) ? upd_target : tgt_q[uidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
      cnt_q <= '0;
    end else begin
      if (cnt_en)
        cnt_q <= cnt_q + 32'd1;
      if (flush_all) begin
        for (int i = 0; i < BP_ENTRIES; i++)
          valid_q[i] <= 1'b0;
      end else if (wr_en) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        tgt_q[uidx]   <= wr_tgt;
        ctr_q[uidx]   <= wr_ctr;
      end
    end
  end

  assign mispredict_count = cnt_q;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BP_ENTRIES, default 16, number of direct-mapped BTB/BHT entries (power of two, 4..64).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have fetch_pc  input  32  PC being fetched this cycle.
REQ-005 SHALL have pred_taken  output  1  predicted taken for fetch_pc.
REQ-006 SHALL have pred_target  output  32  predicted next PC for fetch_pc.
REQ-007 SHALL have upd_valid  input  1  resolved control-flow instruction present this cycle.
REQ-008 SHALL have upd_pc  input  32  PC of the resolved instruction.
REQ-009 SHALL have upd_inst_type  input  inst_type_t  ITYPE_BRANCH, ITYPE_JAL or ITYPE_JALR; any other value ignored.
REQ-010 SHALL have upd_taken  input  1  resolved direction from branch resolution.
REQ-011 SHALL have upd_target  input  32  resolved target from branch resolution.
REQ-012 SHALL have upd_mispredict  input  1  resolved outcome differed from prediction.
REQ-013 SHALL have flush_all  input  1  synchronous invalidate of all entries.
REQ-014 SHALL have mispredict_count  output  32  count of accepted updates with upd_mispredict=1.

Function
REQ-015 SHALL index with pc[IDX_W+1:2], IDX_W=log2(BP_ENTRIES); tag = pc[31:IDX_W+2].
REQ-016 SHALL store per entry: valid bit, tag, 32-bit target, 2-bit saturating counter (SNT=0, WNT=1, WT=2, ST=3).
REQ-017 SHALL produce lookup combinationally from registered state: hit = valid and tag match; pred_taken = hit and counter[1]; pred_target = stored target if pred_taken, else fetch_pc+4 (mod 2^32).
REQ-018 SHALL make updates visible to lookup from the cycle after the update edge; same-cycle lookup to the updated index returns the pre-update value.
REQ-019 SHALL on update hit, ITYPE_BRANCH: increment counter if upd_taken (saturate at ST), else decrement (saturate at SNT); overwrite target only when upd_taken.
REQ-020 SHALL on update miss, ITYPE_BRANCH, upd_taken=1: allocate (valid=1, new tag, target=upd_target, counter=WT), evicting any occupant.
REQ-021 SHALL on update miss, ITYPE_BRANCH, upd_taken=0: leave the entry unchanged.
REQ-022 SHALL on ITYPE_JAL/ITYPE_JALR update (hit or miss): write valid=1, tag, target=upd_target, counter=ST.
REQ-023 SHALL increment mispredict_count by 1 when upd_valid and upd_mispredict and upd_inst_type is a control type; wrap 0xFFFFFFFF to 0.
REQ-024 SHALL on flush_all clear every valid bit at the edge; counters and targets keep stale values; mispredict_count unaffected.
REQ-025 SHALL give flush_all priority when flush_all and upd_valid coincide: the update is dropped from BTB/BHT, still counts toward mispredict_count.
REQ-026 SHALL keep pred_* valid during reset deassertion (pred_taken=0, pred_target=fetch_pc+4 while all entries are invalid).

Reset
REQ-027 SHALL on rst_n=0, immediately and asynchronously: all valid=0, all counters=WNT, all targets=0, all tags=0, mispredict_count=0.
REQ-028 SHALL abort any in-flight update when reset asserts mid-cycle; no partial entry write survives.

Structure
REQ-029 SHALL take inst_type_t from the shared types package and add to it bp_ctr_t (enum SNT/WNT/WT/ST) and BP_ENTRIES_DEFAULT.
REQ-030 SHALL implement the saturating counter next-state in one sub-module, sat_counter2 (inputs cur, inc; output next; combinational).

Verification
REQ-031 SHALL test: reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-032 SHALL test: update BRANCH pc=0x100, taken=1, target=0x80; next cycle fetch 0x100 -> pred_taken=1, pred_target=0x80; same-cycle fetch -> 0/0x104.
REQ-033 SHALL test: from WT, three not-taken updates at 0x100 -> WNT, SNT, SNT (pred_taken=0); then four taken -> saturates ST.
REQ-034 SHALL test: entry at 0x100 (BP_ENTRIES=16), update JAL pc=0x140 target=0x200 -> 0x140 predicts 0x200 taken, 0x100 misses.
REQ-035 SHALL test: flush_all with simultaneous upd_valid+upd_mispredict -> all lookups miss next cycle, mispredict_count +1.
REQ-036 SHALL test: preload mispredict_count=0xFFFFFFFF via 2^32-1 forced updates or backdoor, one more mispredict -> 0; rst_n pulse mid-update -> all state at reset values.
